id_scoreboard: RTL



---
 rtl/id_scoreboard.sv | 119 +++++++++++
 1 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write scoreboard for the decode stage.
// Tracks outstanding long-latency writes per architectural register with a
// small saturating-free counter each, and raises a hazard (issue_ready = 0)
// on RAW against a pending register or when a register's counter is full.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback clears the
// hazard combinationally; when undefined the wb-to-ready path is removed.

// One tracked register: pending-write counter with clear, inc and guarded dec.
module id_scoreboard_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);
    logic dec_ok;

    // A completion against an empty counter is stale (e.g. flushed) and dropped.
    assign dec_ok = dec && (cnt != '0);

    // Counter update: reset/flush win; inc and dec together cancel out.
    always_ff @(posedge clk) begin
        if (rst || flush)
            cnt <= '0;
        else if (inc && !dec_ok)
            cnt <= cnt + CNT_W'(1);
        else if (dec_ok && !inc)
            cnt <= cnt - CNT_W'(1);
    end
endmodule

module id_scoreboard #(
    parameter int REG_NUM     = 32,
    parameter int REGID_W     = $clog2(REG_NUM),
    parameter int NUM_RS      = 2,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic                      issue_fire,
    input  logic [NUM_RS-1:0]         issue_rs_read,
    input  logic [NUM_RS*REGID_W-1:0] issue_rs_regid,
    input  logic                      issue_reg_write,
    input  logic                      issue_long,
    input  logic [REGID_W-1:0]        issue_reg_regid,
    input  logic                      wb_valid,
    input  logic [REGID_W-1:0]        wb_regid,
    output logic [REG_NUM-1:0]        busy_vec,
    output logic [STALL_CNT_W-1:0]    stall_count
);
    localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [REG_NUM-1:0][CNT_W-1:0] cnt;
    logic [REG_NUM-1:0][CNT_W-1:0] eff_cnt;
    logic [NUM_RS-1:0]             raw;
    logic                          long_wr;
    logic                          waw_full;
    logic                          track;

    assign long_wr = issue_reg_write && issue_long && (issue_reg_regid != '0);
    assign track   = issue_fire && long_wr;

    for (genvar r = 0; r < REG_NUM; r++) begin : g_reg
        if (r == 0) begin : g_zero
            // x0 is hard-wired zero; nothing ever waits on it.
            assign cnt[r] = '0;
        end else begin : g_trk
            logic inc;
            logic dec;
            assign inc = track && (issue_reg_regid == REGID_W'(r));
            assign dec = wb_valid && (wb_regid == REGID_W'(r));
            id_scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .inc   (inc),
                .dec   (dec),
                .cnt   (cnt[r])
            );
        end
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Count as if this cycle's completion had already retired.
        assign eff_cnt[r] = cnt[r] - CNT_W'(wb_valid && (wb_regid == REGID_W'(r)) && (cnt[r] != '0));
`else
        assign eff_cnt[r] = cnt[r];
`endif
        assign busy_vec[r] = (cnt[r] != '0);
    end

    for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
        logic [REGID_W-1:0] rs_id;
        assign rs_id  = issue_rs_regid[i*REGID_W +: REGID_W];
        assign raw[i] = issue_rs_read[i] && (rs_id != '0) && (eff_cnt[rs_id] != '0);
    end

    // A further long write to a full counter would wrap it, so hold issue.
    assign waw_full    = long_wr && (eff_cnt[issue_reg_regid] == CNT_MAX);
    assign issue_ready = !((|raw) || waw_full);

    // Saturating count of stalled cycles; flush cycles are not stalls.
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (issue_valid && !issue_ready && !flush && (stall_count != STALL_MAX))
            stall_count <= stall_count + STALL_CNT_W'(1);
    end

    // Issuing past a hazard corrupts the counters; flag it loudly.
    a_fire_when_ready: assert property (@(posedge clk) disable iff (rst)
        !(issue_fire && !issue_ready));
endmodule
